// File: rtl/loader_pkg.sv
// loader_pkg: state encoding and word geometry shared by the program loader files.
package loader_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W = 32;
    typedef enum logic [2:0] {HDR, DATA, CHK, DONE, ERR} state_t;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs accepted bytes into big-endian 32-bit words.
// word_valid pulses combinationally with the byte that completes a word.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              take,
    input  logic [7:0]        in_byte,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);
    logic [WORD_W-9:0] sr;
    logic [1:0]        cnt;

    assign word       = {sr, in_byte};
    assign word_valid = take && cnt == 2'(BYTES_PER_WORD - 1);

    // stale bytes need no clearing: a full word shifts them all out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (take) begin
            sr  <= {sr[WORD_W-17:0], in_byte};
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: writes a length-prefixed byte stream into instruction RAM.
// Define CHECKSUM_EN to require a trailing modulo-2^32 sum word before load_done.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 201,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              restart,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);
`ifdef CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
    logic [WORD_W-1:0] sum;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t            state, state_next;
    logic [ADDR_W:0]   remaining;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              take;

    assign in_ready = state == HDR || state == DATA || state == CHK;
    assign take     = in_valid && in_ready && !restart;

    word_assembler u_asm (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (restart),
        .take       (take),
        .in_byte    (in_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_next = state;
        case (state)
            HDR:  if (word_valid) state_next = word == '0 ? AFTER_DATA :
                                               word > 32'(DEPTH) ? ERR : DATA;
            DATA: if (word_valid && remaining == (ADDR_W+1)'(1)) state_next = AFTER_DATA;
`ifdef CHECKSUM_EN
            CHK:  if (word_valid) state_next = word == sum ? DONE : ERR;
`endif
            default: ;
        endcase
        if (restart) state_next = HDR;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= HDR;
        else          state <= state_next;
    end

    // flags follow the next state so they rise on the edge that enters DONE/ERR
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_we       <= 1'b0;
            mem_addr     <= ADDR_W'(BASE_ADDR);
            mem_wdata    <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            remaining    <= '0;
`ifdef CHECKSUM_EN
            sum          <= '0;
`endif
        end else begin
            mem_we     <= 1'b0;
            load_done  <= state_next == DONE;
            load_error <= state_next == ERR;
            if (restart) begin
                words_loaded <= '0;
            end else if (word_valid && state == HDR) begin
                remaining <= word[ADDR_W:0];
`ifdef CHECKSUM_EN
                sum       <= '0;
`endif
            end else if (word_valid && state == DATA) begin
                mem_we       <= 1'b1;
                mem_wdata    <= word;
                mem_addr     <= ADDR_W'(BASE_ADDR) + words_loaded[ADDR_W-1:0];
                words_loaded <= words_loaded + 1'b1;
                remaining    <= remaining - 1'b1;
`ifdef CHECKSUM_EN
                sum          <= sum + word;
`endif
            end
        end
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Writer side of the CPU instruction store. Accepts a byte stream (UART/host link), assembles 32-bit big-endian instruction words and writes them into instruction RAM at consecutive addresses. Asserts a sticky done flag that hands control to the CPU fetch path, in the same way the boot ROM's boot flag does.

Parameters:
ADDR_W, 8, instruction RAM address width
DEPTH, 201, number of instruction RAM words; maximum loadable program length
BASE_ADDR, 0, first RAM address written

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
restart  in  1  synchronous; abort or finish, return to HDR
in_byte  in  8  stream byte
in_valid  in  1  in_byte valid
in_ready  out  1  loader accepts byte; transfer = in_valid & in_ready at posedge
mem_we  out  1  one-cycle instruction RAM write strobe
mem_addr  out  ADDR_W  write address
mem_wdata  out  32  write data
load_done  out  1  sticky: program fully written
load_error  out  1  sticky: bad length (or checksum)
words_loaded  out  ADDR_W+1  count of data words written

Behaviour:
- Reset (async, reset_n=0): state=HDR; all outputs 0 except in_ready=1; byte counter=0; words_loaded=0; mem_addr=BASE_ADDR.
- Word assembly: 2-bit byte counter; first byte -> bits 31:24, fourth -> 7:0; counter wraps 3->0 on word completion.
- HDR: the first word is length N (unsigned 32-bit).
  - N==0 -> DONE, load_done=1 next cycle, no writes.
  - N>DEPTH -> ERR, load_error=1.
  - Otherwise remaining=N, go to DATA.
- DATA: on the edge accepting the 4th byte of a word, register mem_we=1, mem_wdata=word, mem_addr=BASE_ADDR+words_loaded; words_loaded increments on the same edge. mem_we is high for exactly one cycle (write latency = 1 cycle after final byte). On the last word: next state DONE; load_done rises in the same cycle as the final mem_we.
- in_ready=1 in HDR/DATA(/CHK); 0 in DONE and ERR. Bytes presented there are ignored and not consumed.
- DONE/ERR hold until restart or reset.
- restart=1 in any state (mid-word included): next state HDR; byte counter, words_loaded, load_done, load_error cleared; mem_we forced 0. Any byte offered on the same edge is dropped. restart has priority over a simultaneous byte transfer.
- Address arithmetic is modulo 2^ADDR_W. The N<=DEPTH check guarantees no wrap when BASE_ADDR+DEPTH<=2^ADDR_W.
- in_valid low between bytes only stalls; there is no timeout.

Optional Feature:
CHECKSUM_EN.
- With the macro: after N data words the state goes to CHK, which receives one more word C. If C equals the 32-bit modulo sum of the N data words -> DONE; otherwise -> ERR with load_error=1 (the data remains written). N==0 expects C==0.
- Without the macro: there is no CHK state, and DONE is entered directly after the last data word.

Decomposition:
- loader_pkg:
  - state enum (HDR, DATA, CHK, DONE, ERR)
  - BYTES_PER_WORD=4
  - WORD_W=32
- One natural sub-module: word_assembler (byte shift register, byte counter, word_valid pulse, sync clear). program_loader holds the FSM, address/count and checksum accumulator.

Test Plan:
- Stream length 3 then words 0x54000400, 0x31600000, 0x60000000 at one byte/cycle -> three mem_we pulses at addr 0,1,2 with those data; load_done=1 with the third pulse; words_loaded=3; in_ready=0 afterwards.
- Length 0 -> no mem_we; load_done=1 one cycle after the 4th header byte.
- Length 202 (DEPTH+1) -> load_error=1, no writes, in_ready=0.
- Length 2, restart after 2 bytes of the first data word, then length 1, word 0xDEADBEEF -> single write addr 0 data 0xDEADBEEF; no stale-byte corruption.
- in_valid toggled randomly, and reset_n pulsed low mid-DATA -> all outputs return to reset values immediately (async); the reload then succeeds.
- CHECKSUM_EN: words 0xFFFFFFFF, 0x00000002, checksum 0x00000001 -> load_done. Checksum 0x00000002 -> load_error=1, both words still written.
